// File: rtl/disp_cmdwr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_cmdwr_pkg
// Description : Shared types and constants for the display command writer.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_cmdwr_pkg;

    localparam int SYNC_STAGES          = 2;
    localparam int QUEUE_DEPTH          = 4;
    localparam int DEF_SETUP_CYCLES     = 1;
    localparam int DEF_STROBE_CYCLES    = 2;
    localparam int DEF_HOLD_CYCLES      = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/disp_cmd_writer_sync_ff2.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff2
// Description : Two-flop synchronizer; resets to 0 so the FIFO reads as full.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff2 (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/disp_cmd_writer.sv
`default_nettype none
// ============================================================================
// Module      : disp_cmd_writer
// Description : Buffers command bytes and writes them to an external FIFO with
//               programmable setup/strobe/hold timing. Define
//               DISP_CMDWR_QUEUE_EN for a 4-entry queue instead of one register.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_cmd_writer
    import disp_cmdwr_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       nff_in,
    output logic [7:0] fifo_data,
    output logic       fifo_nwr,
    output logic       busy
);

    localparam logic [3:0] c_SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] c_STROBE_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] c_HOLD_LAST   = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] c_GAP_LAST    = 4'(SYNC_STAGES - 1);

    wr_state_t  r_state;
    wr_state_t  w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_nwr;
    logic [7:0] r_data;
    logic       r_rdy_en;
    logic       w_nff_s;
    logic       w_empty;
    logic       w_full;
    logic       w_push;
    logic       w_pop;
    logic       w_load;
    logic [7:0] w_head;

    sync_ff2 u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (nff_in),
        .q    (w_nff_s)
    );

    // r_rdy_en keeps cmd_ready low on every reset edge and the cycle after it.
    assign cmd_ready = r_rdy_en & ~w_full;
    assign w_push    = cmd_valid & cmd_ready;
    assign w_pop     = (r_state == ST_HOLD) && (r_cnt == 4'd0);
    assign w_load    = (r_state == ST_IDLE) && (w_state_nxt == ST_SETUP);

`ifdef DISP_CMDWR_QUEUE_EN
    localparam int               c_PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W + 1)'(QUEUE_DEPTH);

    logic [7:0]         r_mem [QUEUE_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);
    assign w_head  = r_mem[r_rd_ptr];
`else
    logic       r_hold_vld;
    logic [7:0] r_hold;

    // Push needs an empty register and pop needs a full one, so they never coincide.
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_hold_vld <= 1'b0;
            r_hold     <= 8'h00;
        end else if (w_push) begin
            r_hold_vld <= 1'b1;
            r_hold     <= cmd_data;
        end else if (w_pop) begin
            r_hold_vld <= 1'b0;
        end
    end

    assign w_empty = ~r_hold_vld;
    assign w_full  = r_hold_vld;
    assign w_head  = r_hold;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && w_nff_s) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = c_SETUP_LAST;
                end
            end
            ST_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = c_STROBE_LAST;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = c_HOLD_LAST;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = c_GAP_LAST;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_GAP: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // The strobe is registered from the next state so it leaves a flop cleanly.
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_nwr    <= 1'b1;
            r_data   <= 8'h00;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_nwr    <= (w_state_nxt != ST_STROBE);
            r_rdy_en <= 1'b1;
            if (w_load) begin
                r_data <= w_head;
            end
        end
    end

    assign fifo_nwr  = r_nwr;
    assign fifo_data = r_data;
    assign busy      = ~w_empty | (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_disp_cmd_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_cmd_writer
// Description : Self-checking bench: timeline model of the writer plus
//               directed scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_cmd_writer;

    localparam int S  = 1;
    localparam int ST = 2;
    localparam int H  = 1;
`ifdef DISP_CMDWR_QUEUE_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       nff_in;
    logic [7:0] fifo_data;
    logic       fifo_nwr;
    logic       busy;

    always #5 clk = ~clk;

    disp_cmd_writer #(
        .SETUP_CYCLES  (S),
        .STROBE_CYCLES (ST),
        .HOLD_CYCLES   (H)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .nff_in    (nff_in),
        .fifo_data (fifo_data),
        .fifo_nwr  (fifo_nwr),
        .busy      (busy)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- timeline model ----------------
    // A write that starts (byte loaded) at edge t0 strobes low after edges
    // t0+S .. t0+S+ST-1, pops at t0+S+ST+H and is idle again after t0+S+ST+H+2.
    logic [7:0] q[$];
    int         edge_no  = 0;
    int         start_e  = -1;
    logic [7:0] m_data   = 8'h00;
    bit         m_rdy    = 1'b0;
    bit         m_acc;
    bit         nff_h1 = 1'b0, nff_h2 = 1'b0;
    bit         rst_h1 = 1'b1, rst_h2 = 1'b1;
    bit         chk_en = 1'b0;
    logic       exp_nwr, exp_busy, exp_ready;
    logic [7:0] exp_data;

    task automatic model_step();
        int  t_end;
        bit  nff_s;
        bit  pop;
        t_end = S + ST + H;
        nff_s = !(rst_h1 || rst_h2) && nff_h2;
        m_acc = 1'b0;
        pop   = 1'b0;
        if (nrst) begin
            q.delete();
            start_e = -1;
            m_data  = 8'h00;
            m_rdy   = 1'b0;
            chk_en  = 1'b1;
        end else begin
            m_acc = cmd_valid && m_rdy && (q.size() < DEPTH);
            if (start_e < 0) begin
                if (q.size() > 0 && nff_s) begin
                    start_e = edge_no;
                    m_data  = q[0];
                end
            end else begin
                if (edge_no == start_e + t_end) pop = 1'b1;
                if (edge_no == start_e + t_end + 2) start_e = -1;
            end
            if (pop) void'(q.pop_front());
            if (m_acc) q.push_back(cmd_data);
            m_rdy = 1'b1;
        end
        exp_nwr   = !(start_e >= 0 && edge_no >= start_e + S && edge_no < start_e + S + ST);
        exp_data  = m_data;
        exp_busy  = (q.size() > 0) || (start_e >= 0);
        exp_ready = m_rdy && (q.size() < DEPTH);
        nff_h2 = nff_h1;  nff_h1 = nff_in;
        rst_h2 = rst_h1;  rst_h1 = nrst;
        edge_no++;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("model_nwr",   {31'd0, fifo_nwr},  {31'd0, exp_nwr});
            check("model_data",  {24'd0, fifo_data}, {24'd0, exp_data});
            check("model_busy",  {31'd0, busy},      {31'd0, exp_busy});
            check("model_ready", {31'd0, cmd_ready}, {31'd0, exp_ready});
        end
    end

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_low(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (fifo_nwr === 1'b0) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    int lit_nwr  [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
    int lit_busy [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int lit_ready[8] = '{0, 0, 0, 0, 0, 1, 1, 1};

    initial begin
        int   lows;
        int   first_low;
        int   falls;
        logic prev;
        bit   p_hold;

        nrst = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; nff_in = 1'b1;
        run(3);
        check("reset_nwr",   {31'd0, fifo_nwr},  32'd1);
        check("reset_data",  {24'd0, fifo_data}, 32'd0);
        check("reset_busy",  {31'd0, busy},      32'd0);
        check("reset_ready", {31'd0, cmd_ready}, 32'd0);
        nrst = 1'b0;
        run(4);

        // Single byte 0xA5: accept edge E, then edges E..E+7.
        cmd_data = 8'hA5; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            check($sformatf("a5_nwr_k%0d", k),   {31'd0, fifo_nwr},  lit_nwr[k]);
            check($sformatf("a5_busy_k%0d", k),  {31'd0, busy},      lit_busy[k]);
            check($sformatf("a5_ready_k%0d", k), {31'd0, cmd_ready}, lit_ready[k]);
            if (k > 0) check($sformatf("a5_data_k%0d", k), {24'd0, fifo_data}, 32'hA5);
        end

        // FIFO full: byte retained, no strobe, then write resumes.
        nff_in = 1'b0;
        run(4);
        cmd_data = 8'h3C; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (fifo_nwr !== 1'b1) lows++;
        end
        check("full_no_strobe", lows, 0);
        check("full_busy", {31'd0, busy}, 32'd1);
        nff_in = 1'b1;
        first_low = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (fifo_nwr === 1'b0 && first_low < 0) first_low = k;
        end
        check("resume_first_low", first_low, 3);
        check("resume_data", {24'd0, fifo_data}, 32'h3C);
        run(10);

        // Full flag rising mid-write: current completes, next held.
        cmd_data = 8'h11; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_low("midfull_strobe_seen");
        tick();
        nff_in = 1'b0;
        cmd_data = 8'h22; cmd_valid = 1'b1;
        falls = 0; prev = fifo_nwr;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_acc) cmd_valid = 1'b0;
            if (prev === 1'b1 && fifo_nwr === 1'b0) falls++;
            prev = fifo_nwr;
        end
        check("midfull_extra_falls", falls, 0);
        check("midfull_nwr_high", {31'd0, fifo_nwr}, 32'd1);
        check("midfull_held_busy", {31'd0, busy}, 32'd1);
        check("midfull_valid_taken", {31'd0, cmd_valid}, 32'd0);
        nff_in = 1'b1;
        run(20);
        check("midfull_drained_data", {24'd0, fifo_data}, 32'h22);
        check("midfull_drained_busy", {31'd0, busy}, 32'd0);

        // Reset during strobe discards the byte.
        cmd_data = 8'h5A; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_low("rststrobe_seen");
        nrst = 1'b1;
        tick();
        check("rststrobe_nwr",  {31'd0, fifo_nwr},  32'd1);
        check("rststrobe_busy", {31'd0, busy},      32'd0);
        check("rststrobe_data", {24'd0, fifo_data}, 32'd0);
        nrst = 1'b0;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fifo_nwr !== 1'b1) lows++;
        end
        check("rststrobe_no_restrobe", lows, 0);

`ifdef DISP_CMDWR_QUEUE_EN
        begin
            int   acc_n;
            int   ready_drop;
            int   wr_n;
            logic [7:0] got[$];
            acc_n = 0; ready_drop = -1;
            prev = fifo_nwr;
            cmd_valid = 1'b1; cmd_data = 8'h01;
            for (int i = 0; i < 80; i++) begin
                tick();
                if (m_acc) begin
                    acc_n++;
                    if (acc_n == 6) cmd_valid = 1'b0;
                    else cmd_data = 8'(acc_n + 1);
                end
                if (cmd_ready === 1'b0 && ready_drop < 0 && acc_n < 6) ready_drop = acc_n;
                if (prev === 1'b0 && fifo_nwr === 1'b1) got.push_back(fifo_data);
                prev = fifo_nwr;
            end
            check("queue_ready_drop_after", ready_drop, 4);
            wr_n = got.size();
            check("queue_write_count", wr_n, 6);
            for (int i = 0; i < wr_n && i < 6; i++)
                check($sformatf("queue_order_%0d", i), {24'd0, got[i]}, i + 1);
        end
`endif

        // Randomized traffic against the model.
        p_hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!p_hold) begin
                cmd_valid = ($urandom_range(0, 1) == 1);
                cmd_data  = 8'($urandom);
            end
            if ($urandom_range(0, 19) == 0) nff_in = ~nff_in;
            nrst = ($urandom_range(0, 299) == 0);
            tick();
            p_hold = cmd_valid && !m_acc && !nrst;
        end
        nrst = 1'b0; cmd_valid = 1'b0; nff_in = 1'b1;
        run(40);
        check("final_idle_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/disp_cmd_writer.md
DISP_CMD_WRITER -- requirements
Module: disp_cmd_writer

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 1: clocks fifo_data is stable before fifo_nwr falls (range 1-15).
REQ-002 SHALL have parameter STROBE_CYCLES, default 2: clocks fifo_nwr is held low (range 1-15).
REQ-003 SHALL have parameter HOLD_CYCLES, default 1: clocks fifo_data is held after fifo_nwr rises (range 1-15).
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port nrst, input, 1: reset, synchronous, active-high; clock clk.
REQ-006 SHALL have port cmd_data, input, 8: command byte from the host-side producer.
REQ-007 SHALL have port cmd_valid, input, 1: cmd_data is valid.
REQ-008 SHALL have port cmd_ready, output, 1: the block accepts a byte on this cycle.
REQ-009 SHALL have port nff_in, input, 1: active-low full flag from the external FIFO (asynchronous).
REQ-010 SHALL have port fifo_data, output, 8: data bus to the FIFO write port.
REQ-011 SHALL have port fifo_nwr, output, 1: active-low write strobe to the FIFO; the FIFO latches on its rising edge.
REQ-012 SHALL have port busy, output, 1: a byte is buffered or a write cycle is in progress.

Function
REQ-013 A byte SHALL be accepted on any rising edge where cmd_valid=1 and cmd_ready=1; a byte presented while cmd_ready=0 SHALL be neither accepted nor lost (the producer holds it).
REQ-014 nff_in SHALL pass through a 2-stage synchronizer; only the synchronized value nff_s SHALL be used.
REQ-015 The write FSM SHALL have states IDLE, SETUP, STROBE, HOLD and GAP.
REQ-016 IDLE: fifo_nwr=1. Exit to SETUP SHALL occur when a byte is buffered and nff_s=1; the head byte SHALL be loaded onto fifo_data at that transition.
REQ-017 SETUP SHALL last SETUP_CYCLES clocks with fifo_nwr=1, then go to STROBE.
REQ-018 STROBE SHALL last STROBE_CYCLES clocks with fifo_nwr=0, then go to HOLD.
REQ-019 HOLD SHALL last HOLD_CYCLES clocks with fifo_nwr=1 and fifo_data unchanged; the head byte SHALL be popped on HOLD exit.
REQ-020 GAP SHALL last 2 clocks (the synchronizer depth) with fifo_nwr=1, then go to IDLE, so that full status after the write is visible before the next check.
REQ-021 nff_s SHALL be sampled only in IDLE; a full flag that asserts during SETUP, STROBE or HOLD SHALL NOT abort the write in progress.
REQ-022 While nff_s=0, the FSM SHALL stay in IDLE indefinitely with the byte retained and fifo_nwr=1.
REQ-023 fifo_nwr SHALL be driven directly from a flop (glitch-free).
REQ-024 With the buffer empty, an acceptance at edge E (nff_s=1) SHALL cause fifo_nwr to fall at edge E+1+SETUP_CYCLES.
REQ-025 Accept and pop on the same edge SHALL both take effect; occupancy SHALL stay unchanged.
REQ-026 busy SHALL be 1 when the buffer is non-empty or the state is not IDLE.

Reset
REQ-027 On any edge with nrst=1: fifo_nwr=1, fifo_data=0, state=IDLE, buffer emptied, busy=0, cmd_ready=0, synchronizer flops=0 (treated as full).
REQ-028 Reset during STROBE SHALL raise fifo_nwr on that edge; the byte is discarded.
REQ-029 cmd_ready SHALL first be allowed to assert on the first edge after nrst deasserts.

Configuration
REQ-030 Macro DISP_CMDWR_QUEUE_EN: when defined, the buffer SHALL be a 4-entry FIFO queue (cmd_ready = not full); when undefined, it SHALL be a single holding register (cmd_ready = empty, and 0 while a byte is outstanding).

Structure
REQ-031 Package disp_cmdwr_pkg SHALL hold the FSM state type, SYNC_STAGES=2, QUEUE_DEPTH=4 and the default timing constants.
REQ-032 The synchronizer SHALL be a separate sub-module, sync_ff2.

Verification
REQ-033 Defaults, nff_in=1, one byte 0xA5 accepted at edge 10: fifo_nwr low at edges 12-13, high at 14, fifo_data=0xA5 edges 11-14, busy=0 after GAP.
REQ-034 nff_in=0, byte 0x3C accepted: fifo_nwr stays 1 for 100 clocks; nff_in->1 -> write of 0x3C begins no earlier than 2 clocks later.
REQ-035 nff_in->0 one clock after fifo_nwr falls: the current write completes; the next byte is held.
REQ-036 nrst=1 during STROBE: fifo_nwr=1 on that edge, busy=0, no further strobe for the discarded byte.
REQ-037 With DISP_CMDWR_QUEUE_EN, back-to-back 0x01..0x06 with cmd_valid continuously high: cmd_ready drops after 4 accepted bytes; all 6 bytes are written in order.
REQ-038 Without DISP_CMDWR_QUEUE_EN: cmd_ready=0 from acceptance until the edge after HOLD exits; there is exactly one strobe per accepted byte.
